clk_gate_ctrl: RTL
==================

Name: clk_gate_ctrl

Overview:
Enable controller that drives CLK_EN of the latch-based clock gate feeding a gated domain, such as the ALU clock. Client blocks in the reference domain raise per-client requests. The controller wakes the gated clock, lets it settle for a fixed number of cycles, and then grants. After the last request drops, it keeps the clock running for a hysteresis window before gating it off. It also keeps a saturating count of enabled cycles for power/debug status.

Parameters:
NUM_REQ, 2, number of requesting clients (≥1)
WAKE_CYCLES, 2, cycles from CLK_EN rise to first GNT (≥1)
HOLD_CYCLES, 4, idle cycles CLK_EN stays high after last request (0 = drop immediately)
CNT_W, 4, width of internal wake/hold counter; must hold max(WAKE_CYCLES, HOLD_CYCLES)

Ports:
CLK  in  1  reference (ungated) clock
RST  in  1  asynchronous reset, active-low
REQ  in  NUM_REQ  per-client clock request, level
TEST_EN  in  1  forces clock on; acts as an extra request with no grant
CNT_CLR  in  1  synchronous clear of EN_CYCLES
CLK_EN  out  1  registered enable to the clock gate
GNT  out  NUM_REQ  per-client grant: gated clock is running and settled
CLK_ACTIVE  out  1  registered; high in ACTIVE or HOLD
EN_CYCLES  out  16  saturating count of cycles with CLK_EN=1

Behaviour:
- Reset is asynchronous and active-low on RST. While RST=0:
  - state=IDLE, CLK_EN=0, GNT=0, CLK_ACTIVE=0, EN_CYCLES=0, internal counter=0.
  - Asserting reset mid-operation clears everything immediately, with no hold window.
- All outputs are driven directly from flops; there is no combinational path from any input to CLK_EN.
- Let any = |REQ | TEST_EN, sampled at each rising CLK edge.
- IDLE:
  - any=1 -> WAKE, CLK_EN<=1, cnt<=0.
  - Otherwise stay in IDLE with CLK_EN=0.
- WAKE:
  - GNT=0.
  - When cnt==WAKE_CYCLES-1 -> ACTIVE and GNT<=REQ. Otherwise cnt++.
  - The first GNT therefore appears WAKE_CYCLES edges after the edge that raised CLK_EN.
  - Requests that drop during WAKE do not abort the wake. If REQ==0 and TEST_EN==0 at the end of WAKE, go straight to HOLD with GNT<=0.
- ACTIVE:
  - GNT<=REQ every edge, so a new or departing client sees one-cycle latency.
  - any=0 -> HOLD, GNT<=0, cnt<=0.
- HOLD:
  - CLK_EN stays 1, GNT=0.
  - any=1 -> ACTIVE, GNT<=REQ. There is no wake penalty because the clock never stopped.
  - Else if cnt==HOLD_CYCLES-1 -> IDLE, CLK_EN<=0. Otherwise cnt++.
  - If HOLD_CYCLES=0, ACTIVE goes directly to IDLE and CLK_EN<=0 on the same edge that GNT<=0.
- TEST_EN only keeps the clock on; it never sets any GNT bit.
- Simultaneous events:
  - A request arriving on the same edge as HOLD expiry wins: the block goes to ACTIVE and CLK_EN does not fall.
  - CNT_CLR together with an enabled cycle gives EN_CYCLES<=0; clear has priority.
- EN_CYCLES increments on each edge where CLK_EN=1 (the registered value) and saturates at 0xFFFF.
- CLK_ACTIVE<=1 on entry to ACTIVE or HOLD and <=0 on entry to IDLE or WAKE.

Test Plan:
1. Reset: assert RST=0 with random REQ and TEST_EN -> CLK_EN=0, GNT=0, CLK_ACTIVE=0, EN_CYCLES=0; all outputs held low until RST=1.
2. Basic cycle (WAKE=2, HOLD=4):
   - REQ=01 sampled at edge 0 -> CLK_EN=1 at edge 1, GNT=01 at edge 3.
   - REQ=00 sampled at edge 10 -> GNT=00 at edge 11; CLK_EN stays high through edge 14 and falls at edge 15.
   - EN_CYCLES=14.
3. Re-request in HOLD: same as scenario 2, but REQ=10 at edge 13 -> GNT=10 at edge 14; CLK_EN never falls; CLK_ACTIVE stays 1.
4. Staggered clients: REQ=01, then REQ=11 while ACTIVE -> GNT=11 one edge later; drop bit 0 -> GNT=10 next edge; state remains ACTIVE.
5. Early drop: REQ pulse of one cycle in IDLE -> CLK_EN=1 for WAKE+HOLD=6 cycles; GNT stays 0 throughout.
6. TEST_EN and counter:
   - TEST_EN=1 alone -> CLK_EN=1 after one edge, GNT=0 throughout.
   - Preload/run past 65535 enabled cycles -> EN_CYCLES holds 0xFFFF.
   - CNT_CLR=1 -> EN_CYCLES=0 next edge.
   - RST=0 mid-ACTIVE -> CLK_EN=0 immediately.

Source files
------------

// File: rtl/clk_gate_ctrl.sv
// -----------------------------------------------------------------------------
// clk_gate_ctrl
//
// Enable controller for a latch-based clock gate feeding a gated domain (for
// example the ALU clock). Clients in the reference clock domain raise level
// requests; the controller turns the gated clock on, waits a fixed settle time,
// then grants. When the last request goes away the clock is kept running for a
// hysteresis window before being gated off. A saturating 16-bit counter records
// how many reference cycles the enable was high.
//
// Every output comes straight from a flop, so there is no combinational path
// from any input to the clock-gate enable.
//
// Parameters
//   NUM_REQ     number of requesting clients (>= 1)
//   WAKE_CYCLES edges from enable rise to first grant (>= 1)
//   HOLD_CYCLES idle edges the enable stays high after the last request
//               (0 = gate off on the same edge the grants drop)
//   CNT_W       width of the wake/hold counter, >= bits of max(WAKE, HOLD)
//
// Ports
//   clk_i          reference (ungated) clock
//   rst_ni         asynchronous reset, active-low
//   req_i          per-client clock request, level
//   test_en_i      forces the clock on; a request that never receives a grant
//   cnt_clr_i      synchronous clear of en_cycles_o (wins over increment)
//   clk_en_o       registered enable to the clock gate
//   gnt_o          per-client grant: gated clock running and settled
//   clk_active_o   registered, high while in ACTIVE or HOLD
//   en_cycles_o    saturating count of cycles with clk_en_o = 1
// -----------------------------------------------------------------------------
module clk_gate_ctrl #(
   parameter int unsigned NUM_REQ     = 2,
   parameter int unsigned WAKE_CYCLES = 2,
   parameter int unsigned HOLD_CYCLES = 4,
   parameter int unsigned CNT_W       = 4
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic [NUM_REQ-1:0] req_i,
   input  logic               test_en_i,
   input  logic               cnt_clr_i,
   output logic               clk_en_o,
   output logic [NUM_REQ-1:0] gnt_o,
   output logic               clk_active_o,
   output logic [15:0]        en_cycles_o
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WAKE   = 2'd1,
      ST_ACTIVE = 2'd2,
      ST_HOLD   = 2'd3
   } state_e;

   // Terminal counter values. HOLD_LAST is never used when HOLD_CYCLES is 0,
   // the guard only keeps the constant from wrapping.
   localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST =
      CNT_W'((HOLD_CYCLES == 0) ? 0 : (HOLD_CYCLES - 1));
   localparam bit               HOLD_NONE = (HOLD_CYCLES == 0);
   localparam logic [15:0]      CNT_MAX   = 16'hFFFF;

   state_e               state_q,      state_d;
   logic [CNT_W-1:0]     cnt_q,        cnt_d;
   logic                 clk_en_q,     clk_en_d;
   logic [NUM_REQ-1:0]   gnt_q,        gnt_d;
   logic                 clk_active_q, clk_active_d;
   logic [15:0]          en_cycles_q,  en_cycles_d;

   logic                 any_req;

   // TEST_EN counts as a request for keeping the clock on, but grants always
   // follow req_i only.
   assign any_req = (|req_i) | test_en_i;

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      clk_en_d     = clk_en_q;
      gnt_d        = '0;
      clk_active_d = clk_active_q;

      unique case (state_q)
         ST_IDLE: begin
            if (any_req) begin
               state_d      = ST_WAKE;
               clk_en_d     = 1'b1;
               cnt_d        = '0;
               clk_active_d = 1'b0;
            end
         end

         ST_WAKE: begin
            // A wake is never aborted; requests that vanished during the
            // settle time just send us into the hold window afterwards.
            if (cnt_q == WAKE_LAST) begin
               if (any_req) begin
                  state_d      = ST_ACTIVE;
                  gnt_d        = req_i;
                  clk_active_d = 1'b1;
               end else if (HOLD_NONE) begin
                  state_d      = ST_IDLE;
                  clk_en_d     = 1'b0;
                  clk_active_d = 1'b0;
               end else begin
                  state_d      = ST_HOLD;
                  cnt_d        = '0;
                  clk_active_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         ST_ACTIVE: begin
            if (any_req) begin
               gnt_d = req_i;
            end else if (HOLD_NONE) begin
               state_d      = ST_IDLE;
               clk_en_d     = 1'b0;
               clk_active_d = 1'b0;
            end else begin
               state_d = ST_HOLD;
               cnt_d   = '0;
            end
         end

         ST_HOLD: begin
            // A request on the expiry edge wins: the clock never stopped, so
            // no wake penalty is needed.
            if (any_req) begin
               state_d = ST_ACTIVE;
               gnt_d   = req_i;
            end else if (cnt_q == HOLD_LAST) begin
               state_d      = ST_IDLE;
               clk_en_d     = 1'b0;
               clk_active_d = 1'b0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         default: begin
            state_d      = ST_IDLE;
            cnt_d        = '0;
            clk_en_d     = 1'b0;
            clk_active_d = 1'b0;
         end
      endcase
   end

   // Enabled-cycle counter follows the registered enable, i.e. the cycles the
   // gated clock actually ran. Clear has priority over counting.
   always_comb begin
      en_cycles_d = en_cycles_q;
      if (cnt_clr_i) begin
         en_cycles_d = '0;
      end else if (clk_en_q && (en_cycles_q != CNT_MAX)) begin
         en_cycles_d = en_cycles_q + 16'd1;
      end
   end

   // -------------------------------------------------------------------------
   // State registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         clk_en_q     <= 1'b0;
         gnt_q        <= '0;
         clk_active_q <= 1'b0;
         en_cycles_q  <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         clk_en_q     <= clk_en_d;
         gnt_q        <= gnt_d;
         clk_active_q <= clk_active_d;
         en_cycles_q  <= en_cycles_d;
      end
   end

   assign clk_en_o     = clk_en_q;
   assign gnt_o        = gnt_q;
   assign clk_active_o = clk_active_q;
   assign en_cycles_o  = en_cycles_q;

endmodule
